// File: rtl/regfile_multiport.sv
// Multi-port register file: two write ports with a fixed collision rule
// (port 1 wins), NUM_READ combinational read ports, optional same-cycle
// write-to-read forwarding, optional hardwired zero register and a
// registered conflict pulse for same-address double writes.

// One read port: array lookup with optional forwarding and zero masking.
module regfile_read_lane #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                                  reset,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    mem,
  input  logic                                  wr_en0,
  input  logic [ADDR_W-1:0]                     wr_addr0,
  input  logic [DATA_W-1:0]                     wr_data0,
  input  logic                                  wr_en1,
  input  logic [ADDR_W-1:0]                     wr_addr1,
  input  logic [DATA_W-1:0]                     wr_data1,
  output logic [DATA_W-1:0]                     data
);

  // Later assignments take priority: reset > zero reg > port 1 > port 0 > array.
  always_comb begin
    data = mem[addr];
    if (BYPASS != 0 && wr_en0 && (wr_addr0 == addr)) data = wr_data0;
    if (BYPASS != 0 && wr_en1 && (wr_addr1 == addr)) data = wr_data1;
    if (ZERO_REG != 0 && (addr == '0))               data = '0;
    if (reset)                                       data = '0;
  end

endmodule

module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         WriteEnable0,
  input  logic [ADDR_W-1:0]            WriteReg0,
  input  logic [DATA_W-1:0]            WriteData0,
  input  logic                         WriteEnable1,
  input  logic [ADDR_W-1:0]            WriteReg1,
  input  logic [DATA_W-1:0]            WriteData1,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadReg,
  output logic [NUM_READ*DATA_W-1:0]   ReadData,
  output logic                         WriteConflict
);

  localparam int DEPTH = 1 << ADDR_W;

  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
    $error("regfile_multiport: NUM_READ must be in 1..4");
  end

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Writes to register 0 are squashed when it is hardwired; this also keeps
  // a zero-register collision from raising the conflict flag.
  logic wr_en0, wr_en1, collide;
  assign wr_en0  = WriteEnable0 && !(ZERO_REG != 0 && (WriteReg0 == '0));
  assign wr_en1  = WriteEnable1 && !(ZERO_REG != 0 && (WriteReg1 == '0));
  assign collide = wr_en0 && wr_en1 && (WriteReg0 == WriteReg1);

  // Array update: port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '0;
    end else begin
      if (wr_en0) mem[WriteReg0] <= WriteData0;
      if (wr_en1) mem[WriteReg1] <= WriteData1;
    end
  end

  // One-cycle conflict pulse per colliding cycle.
  always_ff @(posedge clock) begin
    if (reset) WriteConflict <= 1'b0;
    else       WriteConflict <= collide;
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_lane
    regfile_read_lane #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_lane (
      .reset    (reset),
      .addr     (ReadReg[i*ADDR_W +: ADDR_W]),
      .mem      (mem),
      .wr_en0   (wr_en0),
      .wr_addr0 (WriteReg0),
      .wr_data0 (WriteData0),
      .wr_en1   (wr_en1),
      .wr_addr1 (WriteReg1),
      .wr_data1 (WriteData1),
      .data     (ReadData[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: dut_a (defaults, bypass on) and dut_b (bypass off) share
// stimulus; dut_c is a 4-read, 16-bit, 8-deep build with register 0 writable.
module tb_regfile_multiport;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  rr;
  logic [63:0] rd_a, rd_b;
  logic        cf_a, cf_b;

  logic        c_we0, c_we1;
  logic [2:0]  c_wa0, c_wa1;
  logic [15:0] c_wd0, c_wd1;
  logic [11:0] c_rr;
  logic [63:0] c_rd;
  logic        c_cf;

  regfile_multiport dut_a (
    .clock(clock), .reset(reset),
    .WriteEnable0(we0), .WriteReg0(wa0), .WriteData0(wd0),
    .WriteEnable1(we1), .WriteReg1(wa1), .WriteData1(wd1),
    .ReadReg(rr), .ReadData(rd_a), .WriteConflict(cf_a)
  );

  regfile_multiport #(.BYPASS(0)) dut_b (
    .clock(clock), .reset(reset),
    .WriteEnable0(we0), .WriteReg0(wa0), .WriteData0(wd0),
    .WriteEnable1(we1), .WriteReg1(wa1), .WriteData1(wd1),
    .ReadReg(rr), .ReadData(rd_b), .WriteConflict(cf_b)
  );

  regfile_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_READ(4), .ZERO_REG(0)) dut_c (
    .clock(clock), .reset(reset),
    .WriteEnable0(c_we0), .WriteReg0(c_wa0), .WriteData0(c_wd0),
    .WriteEnable1(c_we1), .WriteReg1(c_wa1), .WriteData1(c_wd1),
    .ReadReg(c_rr), .ReadData(c_rd), .WriteConflict(c_cf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set after this apply to the following edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  initial begin
    idle();
    rr = '0;
    c_we0 = 0; c_we1 = 0; c_wa0 = '0; c_wa1 = '0; c_wd0 = '0; c_wd1 = '0; c_rr = '0;

    // Reset for two cycles, with a write presented that must be discarded.
    reset = 1;
    we0 = 1; wa0 = 5'd9; wd0 = 32'h99999999; rr = {5'd9, 5'd9};
    tick();
    tick();
    #1;
    chk("rst_lanes_forced", rd_a, 64'h0);
    chk("rst_conflict", {63'h0, cf_a}, 64'h0);
    reset = 0;
    idle();
    tick();
    chk("post_rst_conflict", {63'h0, cf_a}, 64'h0);
    for (int i = 0; i < 32; i += 2) begin
      rr = {5'(i + 1), 5'(i)};
      #1;
      chk($sformatf("rst_read_r%0d", i), rd_a, 64'h0);
    end
    chk("rst_discard_b", rd_b, 64'h0);

    // Independent writes on both ports.
    we0 = 1; wa0 = 5'd1; wd0 = 32'hA5A5A5A5;
    we1 = 1; wa1 = 5'd2; wd1 = 32'h5A5A5A5A;
    tick();
    idle();
    rr = {5'd1, 5'd2};
    #1;
    chk("dual_write_a", rd_a, {32'hA5A5A5A5, 32'h5A5A5A5A});
    chk("dual_write_b", rd_b, {32'hA5A5A5A5, 32'h5A5A5A5A});
    chk("dual_write_nocf", {63'h0, cf_a}, 64'h0);

    // Collision on r7: port 1 wins, also on the bypass path.
    we0 = 1; wa0 = 5'd7; wd0 = 32'h11111111;
    we1 = 1; wa1 = 5'd7; wd1 = 32'h22222222;
    rr = {5'd7, 5'd7};
    #1;
    chk("col_bypass_a", rd_a, {2{32'h22222222}});
    chk("col_nobypass_b", rd_b, 64'h0);
    tick();
    idle();
    #1;
    chk("col_data", rd_a, {2{32'h22222222}});
    chk("col_cf_set", {63'h0, cf_a}, 64'h1);
    chk("col_cf_set_b", {63'h0, cf_b}, 64'h1);
    tick();
    chk("col_cf_clear", {63'h0, cf_a}, 64'h0);

    // Back-to-back collisions on r8 hold the flag, then it drops.
    we0 = 1; wa0 = 5'd8; wd0 = 32'h1; we1 = 1; wa1 = 5'd8; wd1 = 32'h2;
    tick();
    chk("b2b_cf_1", {63'h0, cf_a}, 64'h1);
    wd0 = 32'h3; wd1 = 32'h4;
    tick();
    chk("b2b_cf_2", {63'h0, cf_a}, 64'h1);
    idle();
    rr = {5'd8, 5'd8};
    #1;
    chk("b2b_data", rd_a, {2{32'h4}});
    tick();
    chk("b2b_cf_drop", {63'h0, cf_a}, 64'h0);

    // Collision on hardwired r0: ignored, no flag, bypass still returns 0.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; we1 = 1; wa1 = 5'd0; wd1 = 32'hEEEEEEEE;
    rr = {5'd0, 5'd0};
    #1;
    chk("zero_bypass", rd_a, 64'h0);
    tick();
    idle();
    #1;
    chk("zero_read", rd_a, 64'h0);
    chk("zero_no_cf", {63'h0, cf_a}, 64'h0);

    // Forwarding: old r3 value visible without bypass, new with bypass.
    we0 = 1; wa0 = 5'd3; wd0 = 32'h01020304;
    tick();
    we0 = 1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
    rr = {5'd3, 5'd3};
    #1;
    chk("byp_new_a", rd_a, {2{32'hDEADBEEF}});
    chk("byp_old_b", rd_b, {2{32'h01020304}});
    tick();
    idle();
    #1;
    chk("byp_next_b", rd_b, {2{32'hDEADBEEF}});

    // Different-address forwarding from both ports at once.
    we0 = 1; wa0 = 5'd10; wd0 = 32'h0000AAAA;
    we1 = 1; wa1 = 5'd11; wd1 = 32'h0000BBBB;
    rr = {5'd11, 5'd10};
    #1;
    chk("byp_two_ports", rd_a, {32'h0000BBBB, 32'h0000AAAA});
    tick();
    idle();

    // Reset mid-operation wipes the preceding write and the in-reset write.
    we0 = 1; wa0 = 5'd5; wd0 = 32'hCAFEF00D;
    tick();
    reset = 1;
    we0 = 1; wa0 = 5'd5; wd0 = 32'h12345678;
    rr = {5'd5, 5'd5};
    #1;
    chk("mid_rst_forced", rd_a, 64'h0);
    tick();
    reset = 0;
    idle();
    #1;
    chk("mid_rst_r5", rd_a, 64'h0);
    chk("mid_rst_r3_b", {32'h0, rd_b[31:0]}, 64'h0);
    we0 = 1; wa0 = 5'd5; wd0 = 32'h00000077;
    tick();
    idle();
    #1;
    chk("post_rst_write", rd_a, {2{32'h00000077}});

    // dut_c: 4 lanes, 16 bits, 8 deep, r0 writable.
    c_we1 = 1; c_wa1 = 3'd0; c_wd1 = 16'hABCD;
    for (int n = 1; n < 8; n++) begin
      c_we0 = 1; c_wa0 = 3'(n); c_wd0 = 16'(16'h0101 * n);
      tick();
      c_we1 = 0;
    end
    c_we0 = 0;
    c_rr = {3'd4, 3'd5, 3'd6, 3'd7};
    #1;
    chk("c_lanes_7654", c_rd, {16'h0404, 16'h0505, 16'h0606, 16'h0707});
    c_rr = {3'd0, 3'd1, 3'd2, 3'd3};
    #1;
    chk("c_lanes_3210", c_rd, {16'hABCD, 16'h0101, 16'h0202, 16'h0303});
    c_we0 = 1; c_wa0 = 3'd0; c_wd0 = 16'h1111;
    c_we1 = 1; c_wa1 = 3'd0; c_wd1 = 16'h2222;
    c_rr = '0;
    #1;
    chk("c_r0_bypass", c_rd, {4{16'h2222}});
    tick();
    c_we0 = 0; c_we1 = 0;
    #1;
    chk("c_r0_col_cf", {63'h0, c_cf}, 64'h1);
    chk("c_r0_data", c_rd, {4{16'h2222}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
